add32_seq: RTL and testbench
============================

ADD32_SEQ -- requirements
Module: add32_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits, processed as 4 bytes.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; accepted only when ready=1.
REQ-005 sub  input  1  0: a+b; 1: a-b; captured with operands.
REQ-006 a  input  32  operand A, two's complement, captured on accept.
REQ-007 b  input  32  operand B, two's complement, captured on accept.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 busy  output  1  high in ADD and DONE.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 sum  output  32  result, registered.
REQ-012 cout  output  1  carry out of bit 31 (for sub: 1 = no borrow).
REQ-013 ovf  output  1  signed 32-bit overflow.

Function
REQ-014 Datapath SHALL be exactly one shared 8-bit adder slice with carry-in, used once per cycle; no 32-bit adder.
REQ-015 FSM states: IDLE, ADD, DONE; encoding is free.
REQ-016 IDLE: start=1 at an edge -> capture a, b, sub; clear byte counter; set carry register to sub; go to ADD.
REQ-017 ADD: byte i (counter 0..3) = a[8i+7:8i] + (sub ? ~b[8i+7:8i] : b[8i+7:8i]) + carry; byte result goes to internal partial register; carry register takes slice carry out.
REQ-018 ADD with counter=3 -> go to DONE; sum, cout, ovf SHALL be loaded at that edge.
REQ-019 ovf SHALL equal (sign of a == sign of effective b) and (sign of sum != sign of a), with effective b = sub ? ~b : b.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-021 Latency: accept edge to done high = 5 cycles (4 ADD + 1 DONE); start-to-start throughput = 6 cycles.
REQ-022 start, a, b, sub SHALL be ignored while busy=1; a held-high start SHALL launch a new operation only at the first edge in IDLE.
REQ-023 sum, cout, ovf SHALL hold their last value outside the DONE-entry edge; intermediate bytes SHALL NOT be visible on sum.
REQ-024 Operand changes after the accept edge SHALL NOT affect the result.
REQ-025 Carry SHALL propagate across byte boundaries (e.g. 0x000000FF+1 -> 0x00000100).

Reset
REQ-026 rst=1 SHALL immediately, without a clock: force IDLE; set ready=1, busy=0, done=0, sum=0, cout=0, ovf=0; clear counter, carry, and captured operands.
REQ-027 rst asserted mid-operation SHALL abort it with no done pulse; the first start after rst release SHALL be accepted normally.
REQ-028 start during rst=1 SHALL be ignored.

Verification
REQ-029 a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, ovf=1, cout=0; done exactly 5 cycles after the accept edge.
REQ-030 a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, cout=1, ovf=0 (full 4-byte carry ripple).
REQ-031 a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
REQ-032 start held high, a/b changed every cycle while busy -> result matches the operands captured at accept; next accept exactly 6 cycles after the first.
REQ-033 rst pulsed during the second ADD cycle -> outputs zero asynchronously, no done pulse; a new op after release completes with correct values.
REQ-034 10000 random a, b, sub vectors against golden model a+b / a-b (33-bit, for cout), plus the REQ-019 ovf rule -> zero mismatches.

Source files
------------

// File: rtl/add32_seq.sv
`timescale 1ns/1ps
// Sequential 32-bit add/sub on one shared 8-bit slice, one byte per cycle; done arrives in the
// 5th cycle after accept. No backpressure: start is taken only in IDLE and ignored while busy.
module add32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sub_q, sub_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d;
    logic [23:0] part_q, part_d;
    logic [31:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [8:0]  slice;

    // Operands shift right each ADD cycle, so the slice always reads the low byte.
    always_comb begin
        op_a  = a_q[7:0];
        op_b  = sub_q ? ~b_q[7:0] : b_q[7:0];
        slice = {1'b0, op_a} + {1'b0, op_b} + {8'd0, carry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    cnt_d   = 2'd0;
                    carry_d = sub;
                    state_d = ADD;
                end
            end
            ADD: begin
                carry_d = slice[8];
                a_d     = a_q >> 8;
                b_d     = b_q >> 8;
                part_d  = {slice[7:0], part_q[23:8]};
                cnt_d   = cnt_q + 2'd1;
                // Last byte: op_a/op_b hold the original sign bits of a and effective b.
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                    sum_d   = {slice[7:0], part_q};
                    cout_d  = slice[8];
                    ovf_d   = (op_a[7] == op_b[7]) && (slice[7] != op_a[7]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sub_q   <= 1'b0;
            cnt_q   <= 2'd0;
            carry_q <= 1'b0;
            part_q  <= 24'd0;
            sum_q   <= 32'd0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_add32_seq.sv
`timescale 1ns/1ps
// Bench for add32_seq: behavioural model of the operation timeline plus directed corner cases
// and a long randomized stream with start held high.
module tb_add32_seq;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    add32_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Golden result from plain integer arithmetic.
    function automatic void golden(input logic [31:0] x, input logic [31:0] y, input logic s,
                                   output logic [31:0] r, output logic c, output logic v);
        logic [32:0] u;
        longint      sr;
        if (s) begin
            u  = {1'b0, x} - {1'b0, y};
            c  = (x >= y);
            sr = longint'($signed(x)) - longint'($signed(y));
        end else begin
            u  = {1'b0, x} + {1'b0, y};
            c  = u[32];
            sr = longint'($signed(x)) + longint'($signed(y));
        end
        r = u[31:0];
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endfunction

    // Timeline model: an accepted op is busy for 5 cycles, the 5th is the done cycle, then idle.
    bit          m_run  = 1'b0;
    int          m_age  = 0;
    logic [31:0] m_sum  = 32'd0;
    logic        m_cout = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [31:0] p_sum;
    logic        p_cout;
    logic        p_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run  = 1'b0;
            m_age  = 0;
            m_sum  = 32'd0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_run) begin
            m_age++;
            if (m_age == 4) begin
                m_sum  = p_sum;
                m_cout = p_cout;
                m_ovf  = p_ovf;
            end
            if (m_age == 5) m_run = 1'b0;
        end else if (start) begin
            m_run = 1'b1;
            m_age = 0;
            golden(a, b, sub, p_sum, p_cout, p_ovf);
        end
    end

    always @(negedge clk) begin
        chk("ready", ready, !m_run);
        chk("busy",  busy,  m_run);
        chk("done",  done,  m_run && (m_age == 4));
        chk("sum",   sum,   m_sum);
        chk("cout",  cout,  m_cout);
        chk("ovf",   ovf,   m_ovf);
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("wait_ready", ready, 1'b1);
    endtask

    task automatic op_lit(input string nm, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic ts, input logic [31:0] es, input logic ec, input logic ev);
        int lat;
        wait_ready();
        @(posedge clk); #2;
        a = ta; b = tbv; sub = ts; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"},  lat,  5);
        chk({nm, "_sum"},  sum,  es);
        chk({nm, "_cout"}, cout, ec);
        chk({nm, "_ovf"},  ovf,  ev);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] corners [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFF};
        if ($urandom_range(7) == 0) return corners[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] gs;
        logic        gc, gv;

        // Pin the model itself with hand-computed values.
        golden(32'h7FFFFFFF, 32'h1, 1'b0, gs, gc, gv);
        chk("model_add_ovf", {gs[31:2], gc, gv}, {30'h20000000, 1'b0, 1'b1});
        golden(32'h80000000, 32'h1, 1'b1, gs, gc, gv);
        chk("model_sub_ovf", {gs[31:2], gc, gv}, {30'h1FFFFFFF, 1'b1, 1'b1});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_sum",   sum,   32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        op_lit("max_plus1",  32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1);
        op_lit("ripple",     32'hFFFFFFFF, 32'h1, 1'b0, 32'h00000000, 1'b1, 1'b0);
        op_lit("sub_neg",    32'd5,        32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        op_lit("sub_min",    32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

        // Start held high, operands scrambled every cycle after accept.
        wait_ready();
        @(posedge clk); #2;
        a = 32'h000000FF; b = 32'h1; sub = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        a = $urandom; b = $urandom; sub = 1'($urandom);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("hold_done", done, 1'b1);
                chk("hold_sum",  sum,  32'h00000100);
                chk("hold_cout", cout, 1'b0);
            end
            if (k == 6) chk("hold_gap_busy", busy, 1'b0);
            if (k == 7) chk("hold_reaccept_busy", busy, 1'b1);
            @(posedge clk); #2;
            a = $urandom; b = $urandom; sub = 1'($urandom);
        end
        start = 1'b0;

        // Reset in the second ADD cycle aborts the op; start during reset is ignored.
        wait_ready();
        @(posedge clk); #2;
        a = 32'h12345678; b = 32'h11111111; sub = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1; start = 1'b1;
        #1;
        chk("arst_ready", ready, 1'b1);
        chk("arst_busy",  busy,  1'b0);
        chk("arst_done",  done,  1'b0);
        chk("arst_sum",   sum,   32'd0);
        chk("arst_cout",  cout,  1'b0);
        chk("arst_ovf",   ovf,   1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("arst_hold_busy", busy, 1'b0);
        end
        @(posedge clk); #2;
        rst = 1'b0; start = 1'b0;
        op_lit("after_rst", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

        // 10000 back-to-back random ops (6 cycles each with start held).
        wait_ready();
        @(posedge clk); #2;
        a = rnd_word(); b = rnd_word(); sub = 1'($urandom); start = 1'b1;
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk); #2;
            a = rnd_word(); b = rnd_word(); sub = 1'($urandom);
        end
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
